dmem_banked_ctrl: RTL and testbench

- Parametrised clocked successor to the single-cycle data memory used by the MIPS datapath.
- Word array with byte/half/word access, little-endian byte lanes, and sign/zero-extended loads.
- Misaligned-access detection and a configurable number of wait states behind a valid/ready request and a one-cycle response pulse.
- Sits between the MEM stage and the data store. The stage stalls on req_ready low.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_lane_align.sv | 47 ++++
 rtl/dmem_banked_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dmem_banked_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the banked data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            SZ_WORD: return lane != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte-write mask and replicated store data,
// plus load lane extraction with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = word_i[{lane_i, 3'b000} +: 8];
    assign half_v = lane_i[1] ? word_i[31:16] : word_i[15:0];

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = uns_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = uns_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = word_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_banked_ctrl.sv
// Clocked data memory with valid/ready requests, WAIT_STATES wait cycles and a
// one-cycle response pulse. Define DMEM_PARITY_EN for per-byte even parity.
module dmem_banked_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 128,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
`ifdef DMEM_PARITY_EN
    input  logic              par_inj,
`endif
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, uns_q;
    logic [1:0]         size_q;
    logic [IDX_W+1:0]   addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;
    logic               accept, enter_resp;

    logic               acc_we, acc_uns, mis, par_bad, do_write;
    logic [1:0]         acc_size;
    logic [IDX_W+1:0]   acc_addr;
    logic [31:0]        acc_wdata, word_rd, wdata_sh, ld_data;
    logic [IDX_W-1:0]   acc_idx;
    logic [3:0]         be;
    logic               unused_addr;

    logic [31:0]        mem_q [DEPTH];

    assign unused_addr = ^req_addr[ADDR_W-1:IDX_W+2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept     = req_valid && req_ready;
    // Staying in RESP is only possible through a fresh accept, so this marks every access edge.
    assign enter_resp = (state_d == RESP);

    // With no wait states the access edge is the accept edge, so use the live request.
    assign acc_we    = (WAIT_STATES == 0) ? req_we             : we_q;
    assign acc_size  = (WAIT_STATES == 0) ? req_size           : size_q;
    assign acc_uns   = (WAIT_STATES == 0) ? req_unsigned       : uns_q;
    assign acc_addr  = (WAIT_STATES == 0) ? req_addr[IDX_W+1:0] : addr_q;
    assign acc_wdata = (WAIT_STATES == 0) ? req_wdata          : wdata_q;
    assign acc_idx   = acc_addr[IDX_W+1:2];
    assign word_rd   = mem_q[acc_idx];
    assign mis       = is_misaligned(acc_size, acc_addr[1:0]);
    assign do_write  = enter_resp && acc_we && !mis;

    dmem_lane_align u_align (
        .size_i  (acc_size),
        .lane_i  (acc_addr[1:0]),
        .uns_i   (acc_uns),
        .wdata_i (acc_wdata),
        .word_i  (word_rd),
        .be_o    (be),
        .wdata_o (wdata_sh),
        .rdata_o (ld_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr[IDX_W+1:0];
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                rsp_rdata_q <= (mis || acc_we) ? 32'h0 : ld_data;
                rsp_err_q   <= mis || par_bad;
            end
        end
    end

    // NOTE: the storage array has no reset; clearing it would cost a write port per word.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[acc_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [3:0] par_q [DEPTH];
    logic [3:0] par_rd;

    assign par_rd = par_q[acc_idx];

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) par_q[acc_idx][b] <= (^wdata_sh[8*b +: 8]) ^ par_inj;
            end
        end
    end

    always_comb begin
        par_bad = 1'b0;
        if (!acc_we && !mis) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b] && ((^word_rd[8*b +: 8]) != par_rd[b])) par_bad = 1'b1;
            end
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_banked_ctrl.sv
// Bench for dmem_banked_ctrl: two instances (0 and 3 wait states) checked every
// cycle against a byte-array model, plus literal expectations per directed vector.
module tb_dmem_banked_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rv[2], rwe[2], runs[2], pinj[2], rdy[2], vld[2], err[2];
    logic [1:0]  rsz[2];
    logic [31:0] raddr[2], rwd[2], rd[2];

    always #5 clk = ~clk;

`ifdef DMEM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    dmem_banked_ctrl #(.DEPTH(128), .ADDR_W(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rdy[0]),
        .req_we(rwe[0]), .req_size(rsz[0]), .req_unsigned(runs[0]),
        .req_addr(raddr[0]), .req_wdata(rwd[0]),
`ifdef DMEM_PARITY_EN
        .par_inj(pinj[0]),
`endif
        .rsp_valid(vld[0]), .rsp_rdata(rd[0]), .rsp_err(err[0])
    );

    dmem_banked_ctrl #(.DEPTH(128), .ADDR_W(32), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rdy[1]),
        .req_we(rwe[1]), .req_size(rsz[1]), .req_unsigned(runs[1]),
        .req_addr(raddr[1]), .req_wdata(rwd[1]),
`ifdef DMEM_PARITY_EN
        .par_inj(pinj[1]),
`endif
        .rsp_valid(vld[1]), .rsp_rdata(rd[1]), .rsp_err(err[1])
    );

    typedef struct {
        int        due;
        bit        we;
        bit [1:0]  sz;
        bit        uns;
        bit [31:0] addr;
        bit [31:0] wd;
        bit        inj;
    } req_t;

    logic [7:0]  mb [2][512];
    logic        mp [2][512];
    req_t        pend [2];
    bit          pend_v [2];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] last_rd [2], last_exp [2];
    logic        last_err [2], last_eerr [2];
    int          acc1 [$];
    int          rsp1 [$];

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference behaviour straight from the access rules, on a flat byte array.
    task automatic model_apply(input int k, input req_t r, output logic [31:0] d, output logic e);
        int          n, start;
        logic [31:0] v;
        bit          bad;
        n = (r.sz == 2'd0) ? 1 : (r.sz == 2'd1) ? 2 : 4;
        e = (r.sz == 2'd3) || (r.sz == 2'd1 && r.addr[0]) || (r.sz == 2'd2 && r.addr[1:0] != 2'b00);
        d = 32'h0;
        if (e) return;
        start = int'(r.addr[8:0]);
        if (r.we) begin
            for (int i = 0; i < n; i++) begin
                mb[k][start+i] = r.wd[8*i +: 8];
                mp[k][start+i] = (^r.wd[8*i +: 8]) ^ (PAR && r.inj);
            end
        end else begin
            v   = 32'h0;
            bad = 1'b0;
            for (int i = 0; i < n; i++) begin
                v[8*i +: 8] = mb[k][start+i];
                if (mp[k][start+i] != (^mb[k][start+i])) bad = 1'b1;
            end
            if (n == 1 && !r.uns && v[7])  v = v | 32'hFFFF_FF00;
            if (n == 2 && !r.uns && v[15]) v = v | 32'hFFFF_0000;
            d = v;
            e = PAR && bad;
        end
    endtask

    logic [31:0] ed;
    logic        ee;
    bit          erdy;

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                pend_v[k] = 1'b0;
                check($sformatf("rst_valid%0d", k), 32'(vld[k]), 32'd0);
                check($sformatf("rst_rdata%0d", k), rd[k], 32'h0);
                check($sformatf("rst_err%0d", k), 32'(err[k]), 32'd0);
            end else begin
                erdy = !(pend_v[k] && pend[k].due > cyc);
                check($sformatf("ready%0d", k), 32'(rdy[k]), 32'(erdy));
                if (pend_v[k] && pend[k].due == cyc) begin
                    model_apply(k, pend[k], ed, ee);
                    check($sformatf("rsp_valid%0d", k), 32'(vld[k]), 32'd1);
                    check($sformatf("rsp_rdata%0d", k), rd[k], ed);
                    check($sformatf("rsp_err%0d", k), 32'(err[k]), 32'(ee));
                    last_rd[k]   = rd[k];
                    last_err[k]  = err[k];
                    last_exp[k]  = ed;
                    last_eerr[k] = ee;
                    pend_v[k]    = 1'b0;
                    if (k == 1) rsp1.push_back(cyc + 1);
                end else begin
                    check($sformatf("idle_valid%0d", k), 32'(vld[k]), 32'd0);
                end
                if (erdy && rv[k]) begin
                    pend[k] = '{due: cyc + 1 + ws_of(k), we: rwe[k], sz: rsz[k], uns: runs[k],
                                addr: raddr[k], wd: rwd[k], inj: pinj[k]};
                    pend_v[k] = 1'b1;
                    if (k == 1) acc1.push_back(cyc + 1);
                end
            end
        end
    end

    task automatic do_req(input int k, input bit we, input bit [1:0] sz, input bit uns,
                          input bit [31:0] a, input bit [31:0] wd, input bit inj, input bit wait_rsp);
        bit acc;
        int t;
        @(posedge clk);
        #1;
        rv[k] = 1'b1; rwe[k] = we; rsz[k] = sz; runs[k] = uns;
        raddr[k] = a; rwd[k] = wd; pinj[k] = inj;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            if (rdy[k]) acc = 1'b1;
        end
        if (!acc) begin
            #1;
            rv[k] = 1'b0;
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        if (!wait_rsp) return;
        @(posedge clk);
        #1;
        rv[k] = 1'b0;
        t = 0;
        while (pend_v[k] && t < 60) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (pend_v[k]) check("rsp_timeout", 32'd0, 32'd1);
        pinj[k] = 1'b0;
    endtask

    task automatic expect_last(input int k, input string nm, input logic [31:0] r, input logic e);
        check({nm, "_rdata"}, last_rd[k], r);
        check({nm, "_err"}, 32'(last_err[k]), 32'(e));
        check({nm, "_model"}, last_exp[k], r);
    endtask

    int n_rsp;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rv[k] = 1'b0; rwe[k] = 1'b0; rsz[k] = 2'b00; runs[k] = 1'b0;
            raddr[k] = 32'h0; rwd[k] = 32'h0; pinj[k] = 1'b0;
            for (int i = 0; i < 512; i++) begin
                mb[k][i] = 8'h00;
                mp[k][i] = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero wait states: word round trip, lanes, extension, misalignment, wrap.
        do_req(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 1);
        do_req(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, 1);
        expect_last(0, "lw_10", 32'hDEADBEEF, 1'b0);
        do_req(0, 1, 2'd2, 0, 32'h20, 32'h0, 0, 1);
        do_req(0, 1, 2'd0, 0, 32'h21, 32'h80, 0, 1);
        do_req(0, 0, 2'd0, 0, 32'h21, 32'h0, 0, 1);
        expect_last(0, "lb_21", 32'hFFFFFF80, 1'b0);
        do_req(0, 0, 2'd0, 1, 32'h21, 32'h0, 0, 1);
        expect_last(0, "lbu_21", 32'h00000080, 1'b0);
        do_req(0, 1, 2'd1, 0, 32'h22, 32'h8001, 0, 1);
        do_req(0, 0, 2'd2, 0, 32'h20, 32'h0, 0, 1);
        expect_last(0, "lw_20", 32'h80018000, 1'b0);
        do_req(0, 0, 2'd1, 0, 32'h22, 32'h0, 0, 1);
        expect_last(0, "lh_22", 32'hFFFF8001, 1'b0);
        do_req(0, 0, 2'd2, 0, 32'h13, 32'h0, 0, 1);
        expect_last(0, "lw_13", 32'h0, 1'b1);
        do_req(0, 1, 2'd2, 0, 32'h13, 32'h55555555, 0, 1);
        expect_last(0, "sw_13", 32'h0, 1'b1);
        do_req(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, 1);
        expect_last(0, "lw_10_after", 32'hDEADBEEF, 1'b0);
        do_req(0, 1, 2'd1, 0, 32'h11, 32'h1234, 0, 1);
        expect_last(0, "sh_11", 32'h0, 1'b1);
        do_req(0, 0, 2'd3, 0, 32'h10, 32'h0, 0, 1);
        expect_last(0, "size_11", 32'h0, 1'b1);
        do_req(0, 1, 2'd2, 0, 32'h200, 32'h12345678, 0, 1);
        do_req(0, 0, 2'd2, 0, 32'h0, 32'h0, 0, 1);
        expect_last(0, "wrap_lw_0", 32'h12345678, 1'b0);

`ifdef DMEM_PARITY_EN
        do_req(0, 1, 2'd2, 0, 32'h30, 32'h0, 0, 1);
        do_req(0, 1, 2'd0, 0, 32'h30, 32'h7F, 1, 1);
        do_req(0, 0, 2'd0, 0, 32'h30, 32'h0, 0, 1);
        expect_last(0, "par_lb_30", 32'h0000007F, 1'b1);
        do_req(0, 0, 2'd0, 0, 32'h31, 32'h0, 0, 1);
        expect_last(0, "par_lb_31", 32'h0, 1'b0);
`endif

        // Three wait states: latency, back-to-back throughput.
        do_req(1, 1, 2'd2, 0, 32'h40, 32'hCAFEF00D, 0, 0);
        do_req(1, 0, 2'd2, 0, 32'h40, 32'h0, 0, 1);
        expect_last(1, "b2b_lw_40", 32'hCAFEF00D, 1'b0);
        check("b2b_accept_gap", 32'(acc1[acc1.size()-1] - acc1[acc1.size()-2]), 32'd4);
        check("ws3_latency", 32'(rsp1[rsp1.size()-1] - acc1[acc1.size()-1]), 32'd4);

        // Reset while a store waits: it must never commit or respond.
        do_req(1, 1, 2'd2, 0, 32'h4, 32'h11112222, 0, 1);
        n_rsp = rsp1.size();
        do_req(1, 1, 2'd2, 0, 32'h4, 32'hAAAA5555, 0, 0);
        @(posedge clk);
        #1 rv[1] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2 check("rst_no_rsp", 32'(rsp1.size()), 32'(n_rsp));
        do_req(1, 0, 2'd2, 0, 32'h4, 32'h0, 0, 1);
        expect_last(1, "rst_lw_4", 32'h11112222, 1'b0);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
